clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
- Front-panel controller that sequences the hour/minute/second timekeeping datapath.
- Debounces two raw buttons (MODE, INC) and runs a set-time state machine that halts the counters, lets the user edit hour then minute, and commits the result with a one-cycle load pulse.
- Drives the run-enable and load interface of the time counters, plus the display source/blink controls feeding the 7-segment driver.

Parameters:
- DB_COUNT, 4, consecutive differing sample_tick samples required to flip a debounced button (1..15).
- REPEAT_TICKS, 8, sample_ticks between auto-repeat INC pulses while INC held (1..255).
- TIMEOUT_SEC, 30, second_ticks with no press before an edit is abandoned (1..63).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle debounce sampling strobe.
- second_tick  in  1  one-cycle strobe, once per second.
- btn_mode  in  1  raw asynchronous MODE button, active-high.
- btn_inc  in  1  raw asynchronous INC button, active-high.
- cur_hour  in  5  live hour from the time counters.
- cur_minute  in  6  live minute from the time counters.
- run  out  1  counter run enable (1 = counting).
- load  out  1  one-cycle pulse: counters take load_hour/load_minute and clear seconds.
- load_hour  out  5  hour value to load.
- load_minute  out  6  minute value to load.
- show_hour  out  5  hour for display.
- show_minute  out  6  minute for display.
- edit_field  out  2  0 = none, 1 = hour, 2 = minute.
- blink  out  1  1 = blank the edited field.

Behaviour:
- Reset values: state RUN, run=1, load=0, load_hour=0, load_minute=0, edit_field=0, blink=0, debounced buttons=0, all counters=0. show_* = cur_* while in RUN. Reset mid-edit discards the edit values and asserts no load.
- Synchronisation: each button passes through a 2-flop synchroniser before debounce.
- Debounce: per button, a counter increments on each sample_tick where the synchronised input differs from the debounced state. It clears on any sample_tick where they match. When it reaches DB_COUNT, the debounced state flips and the counter clears.
- Press pulses: a debounced 0->1 edge produces a one-cycle press pulse. Release produces nothing.
- INC auto-repeat: while debounced INC = 1, a repeat counter counts sample_ticks. Every REPEAT_TICKS it emits another inc press. The counter clears on release.
- State RUN:
  - run=1, edit_field=0, blink=0, show_* = cur_*.
  - mode press -> SET_HOUR. Capture edit_hour = cur_hour (0 if >23) and edit_minute = cur_minute (0 if >59).
  - inc press is ignored.
- State SET_HOUR:
  - run=0, edit_field=1, show_* = edit_*.
  - inc: edit_hour+1, wrapping 23->0.
  - mode -> SET_MIN.
- State SET_MIN:
  - run=0, edit_field=2.
  - inc: edit_minute+1, wrapping 59->0.
  - mode -> COMMIT.
- State COMMIT (exactly one cycle):
  - run=0, load=1, load_hour=edit_hour, load_minute=edit_minute.
  - Next state RUN; run=1 on the following cycle.
  - load_hour/load_minute hold their values after the pulse.
  - Presses arriving in this cycle are dropped.
- run transitions: run falls in the cycle after the mode press is registered. The counters therefore freeze at most one clock late.
- Simultaneous presses: mode and inc in the same cycle -> mode acts, inc discarded.
- Blink:
  - Cleared to 0 on entry to SET_HOUR/SET_MIN.
  - Toggles on each second_tick while in a SET state.
  - Forced to 0 on any inc press and in RUN/COMMIT.
- Timeout:
  - A 6-bit counter increments on second_tick while in SET_HOUR/SET_MIN. Any press clears it, and a press takes priority over a same-cycle second_tick.
  - Reaching TIMEOUT_SEC -> RUN with no load. Counters resume from their frozen value.
  - The counter clears on every state entry.
- All arithmetic is unsigned at field width. No output changes except on a clock edge or reset; the show_* mux is combinational on registered state.

Test Plan:
- Reset asserted mid-SET_MIN with edit_minute=17 -> immediately run=1, edit_field=0, load=0; after release show_* tracks cur_*.
- Bounce check (DB_COUNT=4): btn_mode high for 3 sample_ticks then low -> no state change. Held 4 sample_ticks -> SET_HOUR, run=0 next cycle.
- cur_hour=23, cur_minute=59; mode, inc, mode, inc, mode -> one-cycle load with load_hour=0, load_minute=0; run=1 the following cycle.
- INC held in SET_MIN from edit_minute=58, REPEAT_TICKS=8, for 8+16 sample_ticks beyond debounce -> edit_minute 59, 0, 1; blink=0 throughout holding.
- SET_HOUR with no presses, TIMEOUT_SEC=30 -> blink toggles on each second_tick; on the 30th tick state=RUN, load never asserted.
- mode and inc press pulses in the same cycle from SET_HOUR with edit_hour=5 -> SET_MIN entered, edit_hour stays 5.

Source files
------------

// File: rtl/clock_set_controller.sv
// Front-panel set-time controller: debounces MODE/INC, runs the hour/minute edit
// state machine and drives run/load to the time counters plus display controls.
module clock_set_controller #(
   parameter int DB_COUNT     = 4,
   parameter int REPEAT_TICKS = 8,
   parameter int TIMEOUT_SEC  = 30
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sample_tick,
   input  logic       second_tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_minute,
   output logic       run,
   output logic       load,
   output logic [4:0] load_hour,
   output logic [5:0] load_minute,
   output logic [4:0] show_hour,
   output logic [5:0] show_minute,
   output logic [1:0] edit_field,
   output logic       blink
);

   localparam logic [3:0] DB_LAST  = 4'(DB_COUNT - 1);
   localparam logic [7:0] REP_LAST = 8'(REPEAT_TICKS - 1);
   localparam logic [5:0] TO_LAST  = 6'(TIMEOUT_SEC - 1);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_SET_HOUR = 2'd1,
      S_SET_MIN  = 2'd2,
      S_COMMIT   = 2'd3
   } state_t;

   state_t     r_state;
   logic       r_mode_s1, r_mode_s2, r_inc_s1, r_inc_s2;
   logic       r_mode_db, r_inc_db, r_mode_db_d, r_inc_db_d;
   logic [3:0] r_mode_cnt, r_inc_cnt;
   logic [7:0] r_rep_cnt;
   logic       r_run, r_load, r_blink;
   logic [1:0] r_edit_field;
   logic [4:0] r_load_hour, r_edit_hour;
   logic [5:0] r_load_minute, r_edit_minute;
   logic [5:0] r_to_cnt;

   logic       w_mode_press, w_inc_press;
   logic [4:0] w_cap_hour;
   logic [5:0] w_cap_minute;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mode_s1   <= 1'b0;
         r_mode_s2   <= 1'b0;
         r_inc_s1    <= 1'b0;
         r_inc_s2    <= 1'b0;
         r_mode_db   <= 1'b0;
         r_inc_db    <= 1'b0;
         r_mode_db_d <= 1'b0;
         r_inc_db_d  <= 1'b0;
         r_mode_cnt  <= 4'd0;
         r_inc_cnt   <= 4'd0;
         r_rep_cnt   <= 8'd0;
      end else begin
         r_mode_s1   <= btn_mode;
         r_mode_s2   <= r_mode_s1;
         r_inc_s1    <= btn_inc;
         r_inc_s2    <= r_inc_s1;
         r_mode_db_d <= r_mode_db;
         r_inc_db_d  <= r_inc_db;
         if (sample_tick) begin
            if (r_mode_s2 == r_mode_db) begin
               r_mode_cnt <= 4'd0;
            end else if (r_mode_cnt == DB_LAST) begin
               r_mode_db  <= ~r_mode_db;
               r_mode_cnt <= 4'd0;
            end else begin
               r_mode_cnt <= r_mode_cnt + 4'd1;
            end
            if (r_inc_s2 == r_inc_db) begin
               r_inc_cnt <= 4'd0;
            end else if (r_inc_cnt == DB_LAST) begin
               r_inc_db  <= ~r_inc_db;
               r_inc_cnt <= 4'd0;
            end else begin
               r_inc_cnt <= r_inc_cnt + 4'd1;
            end
         end
         // Repeat counter only runs while INC is held down (debounced)
         if (!r_inc_db) begin
            r_rep_cnt <= 8'd0;
         end else if (sample_tick) begin
            r_rep_cnt <= (r_rep_cnt == REP_LAST) ? 8'd0 : r_rep_cnt + 8'd1;
         end
      end
   end

   assign w_mode_press = r_mode_db & ~r_mode_db_d;
   assign w_inc_press  = (r_inc_db & ~r_inc_db_d) |
                         (r_inc_db & sample_tick & (r_rep_cnt == REP_LAST));
   assign w_cap_hour   = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
   assign w_cap_minute = (cur_minute > 6'd59) ? 6'd0 : cur_minute;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_RUN;
         r_run         <= 1'b1;
         r_load        <= 1'b0;
         r_load_hour   <= 5'd0;
         r_load_minute <= 6'd0;
         r_edit_field  <= 2'd0;
         r_blink       <= 1'b0;
         r_edit_hour   <= 5'd0;
         r_edit_minute <= 6'd0;
         r_to_cnt      <= 6'd0;
      end else begin
         r_load <= 1'b0;
         case (r_state)
            S_RUN: begin
               r_run        <= 1'b1;
               r_edit_field <= 2'd0;
               r_blink      <= 1'b0;
               if (w_mode_press) begin
                  r_state       <= S_SET_HOUR;
                  r_run         <= 1'b0;
                  r_edit_field  <= 2'd1;
                  r_edit_hour   <= w_cap_hour;
                  r_edit_minute <= w_cap_minute;
                  r_to_cnt      <= 6'd0;
               end
            end
            S_SET_HOUR, S_SET_MIN: begin
               // Mode beats inc, and any press beats a same-cycle second_tick
               if (w_mode_press) begin
                  r_blink  <= 1'b0;
                  r_to_cnt <= 6'd0;
                  if (r_state == S_SET_HOUR) begin
                     r_state      <= S_SET_MIN;
                     r_edit_field <= 2'd2;
                  end else begin
                     r_state       <= S_COMMIT;
                     r_edit_field  <= 2'd0;
                     r_load        <= 1'b1;
                     r_load_hour   <= r_edit_hour;
                     r_load_minute <= r_edit_minute;
                  end
               end else if (w_inc_press) begin
                  r_blink  <= 1'b0;
                  r_to_cnt <= 6'd0;
                  if (r_state == S_SET_HOUR)
                     r_edit_hour <= (r_edit_hour == 5'd23) ? 5'd0 : r_edit_hour + 5'd1;
                  else
                     r_edit_minute <= (r_edit_minute == 6'd59) ? 6'd0 : r_edit_minute + 6'd1;
               end else if (second_tick) begin
                  if (r_to_cnt == TO_LAST) begin
                     r_state      <= S_RUN;
                     r_run        <= 1'b1;
                     r_edit_field <= 2'd0;
                     r_blink      <= 1'b0;
                     r_to_cnt     <= 6'd0;
                  end else begin
                     r_to_cnt <= r_to_cnt + 6'd1;
                     r_blink  <= ~r_blink;
                  end
               end
            end
            S_COMMIT: begin
               r_state  <= S_RUN;
               r_run    <= 1'b1;
               r_to_cnt <= 6'd0;
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign run         = r_run;
   assign load        = r_load;
   assign load_hour   = r_load_hour;
   assign load_minute = r_load_minute;
   assign edit_field  = r_edit_field;
   assign blink       = r_blink;
   assign show_hour   = (r_state == S_RUN) ? cur_hour : r_edit_hour;
   assign show_minute = (r_state == S_RUN) ? cur_minute : r_edit_minute;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed front-panel scenarios plus random
// button activity, all checked cycle by cycle against a behavioural model.
module tb_clock_set_controller;

   localparam int DB_COUNT     = 4;
   localparam int REPEAT_TICKS = 8;
   localparam int TIMEOUT_SEC  = 30;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sample_tick = 1'b0, second_tick = 1'b0;
   logic       btn_mode = 1'b0, btn_inc = 1'b0;
   logic [4:0] cur_hour = 5'd10;
   logic [5:0] cur_minute = 6'd20;
   logic       run, load, blink;
   logic [4:0] load_hour, show_hour;
   logic [5:0] load_minute, show_minute;
   logic [1:0] edit_field;

   clock_set_controller #(
      .DB_COUNT(DB_COUNT), .REPEAT_TICKS(REPEAT_TICKS), .TIMEOUT_SEC(TIMEOUT_SEC)
   ) dut (
      .clock(clock), .reset(reset), .sample_tick(sample_tick), .second_tick(second_tick),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .cur_hour(cur_hour), .cur_minute(cur_minute),
      .run(run), .load(load), .load_hour(load_hour), .load_minute(load_minute),
      .show_hour(show_hour), .show_minute(show_minute), .edit_field(edit_field), .blink(blink)
   );

   always #5 clock = ~clock;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Behavioural reference: mode 0=running, 1=editing hour, 2=editing minute, 3=commit
   int m_mode, m_eh, m_em, m_lh, m_lm, m_blink, m_secs;
   int m_mdb, m_idb, m_mprev, m_iprev, m_mrun, m_irun, m_rep;
   int raw_m[$], raw_i[$];

   task automatic model_reset();
      m_mode = 0; m_eh = 0; m_em = 0; m_lh = 0; m_lm = 0; m_blink = 0; m_secs = 0;
      m_mdb = 0; m_idb = 0; m_mprev = 0; m_iprev = 0; m_mrun = 0; m_irun = 0; m_rep = 0;
      raw_m = '{0, 0};
      raw_i = '{0, 0};
   endtask

   task automatic debounce(input int seen, input int db_in, input int run_in,
                           output int db_out, output int run_out);
      db_out = db_in;
      run_out = run_in;
      if (sample_tick) begin
         if (seen == db_in) run_out = 0;
         else if (run_in + 1 >= DB_COUNT) begin db_out = 1 - db_in; run_out = 0; end
         else run_out = run_in + 1;
      end
   endtask

   task automatic model_edge();
      int mp, ip, seen_m, seen_i;
      mp = (m_mdb == 1 && m_mprev == 0) ? 1 : 0;
      ip = ((m_idb == 1 && m_iprev == 0) ||
            (m_idb == 1 && sample_tick && m_rep == REPEAT_TICKS - 1)) ? 1 : 0;
      case (m_mode)
         0: if (mp != 0) begin
               m_mode = 1;
               m_eh = (int'(cur_hour) > 23) ? 0 : int'(cur_hour);
               m_em = (int'(cur_minute) > 59) ? 0 : int'(cur_minute);
               m_blink = 0; m_secs = 0;
            end
         1, 2: begin
            if (mp != 0) begin
               m_blink = 0; m_secs = 0;
               if (m_mode == 1) m_mode = 2;
               else begin m_mode = 3; m_lh = m_eh; m_lm = m_em; end
            end else if (ip != 0) begin
               m_blink = 0; m_secs = 0;
               if (m_mode == 1) m_eh = (m_eh + 1) % 24;
               else m_em = (m_em + 1) % 60;
            end else if (second_tick) begin
               m_secs++;
               if (m_secs == TIMEOUT_SEC) begin m_mode = 0; m_blink = 0; m_secs = 0; end
               else m_blink = 1 - m_blink;
            end
         end
         default: m_mode = 0;
      endcase
      if (m_idb == 0) m_rep = 0;
      else if (sample_tick) m_rep = (m_rep + 1) % REPEAT_TICKS;
      m_mprev = m_mdb;
      m_iprev = m_idb;
      seen_m = raw_m.pop_front();
      seen_i = raw_i.pop_front();
      debounce(seen_m, m_mdb, m_mrun, m_mdb, m_mrun);
      debounce(seen_i, m_idb, m_irun, m_idb, m_irun);
      raw_m.push_back(int'(btn_mode));
      raw_i.push_back(int'(btn_inc));
   endtask

   function automatic logic [31:0] expected_outputs();
      logic [4:0] sh, lh;
      logic [5:0] sm, lm;
      logic [1:0] fld;
      sh  = (m_mode == 0) ? cur_hour : 5'(m_eh);
      sm  = (m_mode == 0) ? cur_minute : 6'(m_em);
      lh  = 5'(m_lh);
      lm  = 6'(m_lm);
      fld = (m_mode == 1) ? 2'd1 : (m_mode == 2) ? 2'd2 : 2'd0;
      return {5'd0, (m_mode == 0), (m_mode == 3), lh, lm, sh, sm, fld, (m_blink != 0)};
   endfunction

   function automatic logic [31:0] actual_outputs();
      return {5'd0, run, load, load_hour, load_minute, show_hour, show_minute, edit_field, blink};
   endfunction

   int cyc = 0;
   int st_every = 1;
   int sec_every = 0;
   int load_cnt = 0;
   int after_load = 0;
   logic [4:0] ld_h;
   logic [5:0] ld_m;
   logic run_after;

   task automatic cycle();
      sample_tick = ((cyc % st_every) == 0);
      second_tick = (sec_every != 0) && ((cyc % sec_every) == 0);
      @(posedge clock);
      model_edge();
      @(negedge clock);
      cyc++;
      check("outputs", actual_outputs(), expected_outputs());
      if (after_load != 0) begin run_after = run; after_load = 0; end
      if (load) begin load_cnt++; ld_h = load_hour; ld_m = load_minute; after_load = 1; end
   endtask

   task automatic press(input logic m, input logic i, input int hold);
      btn_mode = m;
      btn_inc  = i;
      repeat (hold) cycle();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (10) cycle();
   endtask

   initial begin
      int toggles, to_load, done, last, blink_seen;
      int seq[$];
      int rep_exp[3];
      logic prev_blink;

      rep_exp = '{59, 0, 1};
      model_reset();
      #12;
      check("rst_run", run, 1);
      check("rst_load", load, 0);
      check("rst_field", edit_field, 0);
      check("rst_blink", blink, 0);
      check("rst_load_hm", {load_hour, load_minute}, 0);
      check("rst_show", {show_hour, show_minute}, {5'd10, 6'd20});
      @(negedge clock);
      reset = 1'b0;
      repeat (3) cycle();

      // Bounce: three good samples are not enough, a real press is
      btn_mode = 1'b1;
      repeat (3) cycle();
      btn_mode = 1'b0;
      repeat (8) cycle();
      check("bounce_run", run, 1);
      press(1'b1, 1'b0, 5);
      check("set_field", edit_field, 1);
      check("set_run", run, 0);

      // Idle in SET_HOUR until the edit is abandoned
      sec_every = 3; toggles = 0; to_load = 0; done = 0; prev_blink = blink;
      for (int k = 0; k < 400 && done == 0; k++) begin
         cycle();
         if (load) to_load++;
         if (edit_field != 2'd0 && blink != prev_blink) toggles++;
         prev_blink = blink;
         if (run) done = 1;
      end
      sec_every = 0;
      check("to_done", done, 1);
      check("to_toggles", toggles, 29);
      check("to_load", to_load, 0);
      check("to_show", show_hour, cur_hour);

      // 23:59 with both fields wrapping, then commit
      cur_hour = 5'd23; cur_minute = 6'd59; load_cnt = 0; run_after = 1'b0;
      press(1'b1, 1'b0, 5);
      press(1'b0, 1'b1, 5);
      press(1'b1, 1'b0, 5);
      press(1'b0, 1'b1, 5);
      press(1'b1, 1'b0, 5);
      check("ld_cnt", load_cnt, 1);
      check("ld_hour", ld_h, 0);
      check("ld_min", ld_m, 0);
      check("ld_run_after", run_after, 1);
      check("ld_hold", {load_hour, load_minute}, 0);

      // INC held in SET_MIN from 58: auto-repeat wraps through 0
      cur_hour = 5'd3; cur_minute = 6'd58;
      press(1'b1, 1'b0, 5);
      press(1'b1, 1'b0, 5);
      btn_inc = 1'b1; last = int'(show_minute); blink_seen = 0; seq.delete();
      for (int k = 0; k < 80 && last != 1; k++) begin
         cycle();
         if (blink) blink_seen = 1;
         if (int'(show_minute) != last) begin
            last = int'(show_minute);
            seq.push_back(last);
         end
      end
      btn_inc = 1'b0;
      repeat (10) cycle();
      check("rep_count", seq.size(), 3);
      for (int k = 0; k < 3; k++)
         check($sformatf("rep_val%0d", k), (k < seq.size()) ? seq[k] : 99, rep_exp[k]);
      check("rep_blink", blink_seen, 0);
      press(1'b1, 1'b0, 5);

      // Simultaneous mode+inc in SET_HOUR: mode wins
      cur_hour = 5'd5; cur_minute = 6'd0;
      press(1'b1, 1'b0, 5);
      press(1'b1, 1'b1, 5);
      check("sim_field", edit_field, 2);
      check("sim_hour", show_hour, 5);
      press(1'b1, 1'b0, 5);

      // Asynchronous reset in the middle of a minute edit
      cur_hour = 5'd30; cur_minute = 6'd17;
      press(1'b1, 1'b0, 5);
      press(1'b1, 1'b0, 5);
      check("mid_field_before", edit_field, 2);
      check("mid_min_before", show_minute, 17);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("mid_rst_run", run, 1);
      check("mid_rst_field", edit_field, 0);
      check("mid_rst_load", load, 0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      cur_hour = 5'd7; cur_minute = 6'd33;
      cycle();
      check("mid_show", {show_hour, show_minute}, {5'd7, 6'd33});

      // Random button activity with variable sampling rate
      sec_every = 7;
      for (int blk = 0; blk < 6; blk++) begin
         st_every = int'($urandom_range(1, 2));
         for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 15) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 7) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 31) == 0) cur_hour = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 31) == 0) cur_minute = 6'($urandom_range(0, 63));
            cycle();
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
